// File: rtl/cr16_exec_ctrl.sv
// Multi-cycle execute controller driving the CR16 ALU, register file writeback and PSR.
// Latency: write strobe is 3 cycles after accept; a branch or illegal pulse follows accept by 1 cycle.
// Backpressure: O_INSTR_READY is high only in IDLE. One instruction is in flight at a time.
//
// Ports:
//   I_CLK, I_NRESET          clock (rising edge), asynchronous active-low reset
//   I_INSTR_VALID/I_INSTR    instruction offer; O_INSTR_READY accepts it
//   O_RF_RADDR_A/B           Rsrc / Rdest read addresses; I_RF_RDATA_A/B return one cycle later
//   O_RF_WE/WADDR/WDATA      register file write port, active in WB
//   O_ALU_*                  ALU enable, opcode and operands, non-zero only in EXEC
//   I_ALU_C/I_ALU_STATUS     combinational ALU result and status {N,Z,F,L,C}
//   O_PSR                    processor status register, same bit order as I_ALU_STATUS
//   O_BRANCH_*               Bcond resolution pulse with taken flag and displacement
//   O_ILLEGAL                pulse for an undecodable instruction
module cr16_exec_ctrl #(
  parameter int P_WIDTH = 16
) (
  input  logic               I_CLK,
  input  logic               I_NRESET,
  input  logic               I_INSTR_VALID,
  input  logic [15:0]        I_INSTR,
  output logic               O_INSTR_READY,
  output logic [3:0]         O_RF_RADDR_A,
  output logic [3:0]         O_RF_RADDR_B,
  input  logic [P_WIDTH-1:0] I_RF_RDATA_A,
  input  logic [P_WIDTH-1:0] I_RF_RDATA_B,
  output logic               O_RF_WE,
  output logic [3:0]         O_RF_WADDR,
  output logic [P_WIDTH-1:0] O_RF_WDATA,
  output logic               O_ALU_ENABLE,
  output logic [3:0]         O_ALU_OPCODE,
  output logic [P_WIDTH-1:0] O_ALU_A,
  output logic [P_WIDTH-1:0] O_ALU_B,
  input  logic [P_WIDTH-1:0] I_ALU_C,
  input  logic [4:0]         I_ALU_STATUS,
  output logic [4:0]         O_PSR,
  output logic               O_BRANCH_VALID,
  output logic               O_BRANCH_TAKEN,
  output logic [7:0]         O_BRANCH_DISP,
  output logic               O_ILLEGAL
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_EXEC, ST_WB, ST_BRANCH, ST_ILLEGAL
  } state_t;

  typedef enum logic [1:0] {
    PSR_KEEP, PSR_ALL, PSR_Z
  } psr_mode_t;

  typedef struct packed {
    logic      legal;
    logic      branch;
    logic [3:0] alu_op;
    logic      src_imm;   // source operand is the 8-bit immediate
    logic      imm_sext;  // sign-extend the immediate (arith/move forms)
    logic      is_mov;    // bypass the ALU, write the source operand
    logic      is_shift;  // A = Rdest, B = Rsrc
    logic      is_not;    // A = Rsrc, B unused
    logic      wb_en;
    psr_mode_t psr_mode;
  } dec_t;

  // The RR extension codes and the immediate opcodes share one encoding, so
  // both forms go through the same table keyed on ext (RR) or op (immediate).
  function automatic dec_t decode(input logic [15:0] ins);
    dec_t       d;
    logic [3:0] key;
    d          = '0;
    d.legal    = 1'b1;
    d.wb_en    = 1'b1;
    d.psr_mode = PSR_KEEP;
    key        = 4'h0;
    case (ins[15:12])
      4'h8: begin
        if (ins[7:6] == 2'b01) begin
          d.alu_op   = {2'b10, ins[5:4]};
          d.is_shift = 1'b1;
          d.psr_mode = PSR_Z;
        end else begin
          d.legal = 1'b0;
        end
      end
      4'hC: begin
        d.branch = 1'b1;
        d.wb_en  = 1'b0;
      end
      4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD: begin
        d.src_imm = (ins[15:12] != 4'h0);
        key       = d.src_imm ? ins[15:12] : ins[7:4];
        case (key)
          4'h5: begin d.alu_op = 4'd0; d.psr_mode = PSR_ALL; d.imm_sext = 1'b1; end
          4'h7: begin d.alu_op = 4'd1; d.psr_mode = PSR_ALL; d.imm_sext = 1'b1; end
          4'h9: begin d.alu_op = 4'd3; d.psr_mode = PSR_ALL; d.imm_sext = 1'b1; end
          4'hB: begin d.alu_op = 4'd3; d.psr_mode = PSR_ALL; d.imm_sext = 1'b1; d.wb_en = 1'b0; end
          4'h1: begin d.alu_op = 4'd5; d.psr_mode = PSR_Z; end
          4'h2: begin d.alu_op = 4'd6; d.psr_mode = PSR_Z; end
          4'h3: begin d.alu_op = 4'd7; d.psr_mode = PSR_Z; end
          4'hD: begin d.is_mov = 1'b1; d.imm_sext = 1'b1; end
          4'hE: d.alu_op = 4'd2;
          4'hF: begin d.alu_op = 4'd4; d.is_not = 1'b1; d.psr_mode = PSR_Z; end
          default: d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // psr bit order: 0 C, 1 L, 2 F, 3 Z, 4 N
  function automatic logic cond_true(input logic [4:0] psr, input logic [3:0] cond);
    logic c, l, f, z, n, r;
    c = psr[0]; l = psr[1]; f = psr[2]; z = psr[3]; n = psr[4];
    case (cond)
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = c;
      4'h3: r = !c;
      4'h4: r = l;
      4'h5: r = !l;
      4'h6: r = n;
      4'h7: r = !n;
      4'h8: r = f;
      4'h9: r = !f;
      4'hA: r = !l && !z;
      4'hB: r = l || z;
      4'hC: r = !n && !z;
      4'hD: r = n || z;
      4'hE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t             state, state_nxt;
  logic [15:0]        instr_q;
  logic [P_WIDTH-1:0] res_q;
  logic [4:0]         stat_q;
  logic [4:0]         psr_q;
  dec_t               dec;
  logic               accept;
  logic [P_WIDTH-1:0] imm_ext;
  logic [P_WIDTH-1:0] src_val;

  assign accept = I_INSTR_VALID && (state == ST_IDLE);

  // In IDLE the offered word is decoded to pick the next state; afterwards
  // everything works from the latched copy.
  always_comb begin
    dec     = decode((state == ST_IDLE) ? I_INSTR : instr_q);
    imm_ext = dec.imm_sext ? P_WIDTH'($signed(instr_q[7:0])) : P_WIDTH'(instr_q[7:0]);
    src_val = dec.src_imm ? imm_ext : I_RF_RDATA_A;
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state   <= ST_IDLE;
      instr_q <= '0;
      res_q   <= '0;
      stat_q  <= '0;
      psr_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) instr_q <= I_INSTR;
      if (state == ST_EXEC) begin
        res_q  <= dec.is_mov ? src_val : I_ALU_C;
        stat_q <= I_ALU_STATUS;
      end
      if (state == ST_WB) begin
        case (dec.psr_mode)
          PSR_ALL: psr_q    <= stat_q;
          PSR_Z:   psr_q[3] <= stat_q[3];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!dec.legal)     state_nxt = ST_ILLEGAL;
          else if (dec.branch) state_nxt = ST_BRANCH;
          else                 state_nxt = ST_READ;
        end
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    O_INSTR_READY  = (state == ST_IDLE);
    O_RF_RADDR_A   = instr_q[3:0];
    O_RF_RADDR_B   = instr_q[11:8];
    O_ALU_ENABLE   = 1'b0;
    O_ALU_OPCODE   = 4'h0;
    O_ALU_A        = '0;
    O_ALU_B        = '0;
    O_RF_WE        = 1'b0;
    O_RF_WADDR     = 4'h0;
    O_RF_WDATA     = '0;
    O_BRANCH_VALID = 1'b0;
    O_BRANCH_TAKEN = 1'b0;
    O_BRANCH_DISP  = 8'h0;
    O_ILLEGAL      = (state == ST_ILLEGAL);
    O_PSR          = psr_q;

    if (state == ST_EXEC && !dec.is_mov) begin
      O_ALU_ENABLE = 1'b1;
      O_ALU_OPCODE = dec.alu_op;
      if (dec.is_shift) begin
        O_ALU_A = I_RF_RDATA_B;
        O_ALU_B = I_RF_RDATA_A;
      end else if (dec.is_not) begin
        O_ALU_A = I_RF_RDATA_A;
      end else begin
        // ALU computes B - A, giving Rdest - src for SUB/CMP
        O_ALU_A = src_val;
        O_ALU_B = I_RF_RDATA_B;
      end
    end

    if (state == ST_WB) begin
      O_RF_WE    = dec.wb_en;
      O_RF_WADDR = instr_q[11:8];
      O_RF_WDATA = res_q;
    end

    if (state == ST_BRANCH) begin
      O_BRANCH_VALID = 1'b1;
      O_BRANCH_TAKEN = cond_true(psr_q, instr_q[11:8]);
      O_BRANCH_DISP  = instr_q[7:0];
    end
  end

endmodule
